serv_dbus_resp: RTL and testbench

//  Wishbone-classic data-bus responder: the memory end of the core's dbus.

---
 rtl/serv_dbus_resp.sv | 138 +++++++++++++
 tb/tb_serv_dbus_resp.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_resp.sv
// Wishbone-classic data-bus responder backed by an internal word RAM.
// Each accepted request is served after WAIT wait cycles and completed with a
// single-cycle ack. Out-of-range accesses are acked but have no effect on the
// RAM. They read as zero and set a sticky error flag.
module serv_dbus_resp #(
    parameter int unsigned AW   = 8,
    parameter int unsigned WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Request fields captured at acceptance; byte offset bits are not kept.
    typedef struct packed {
        logic [29:0] word_adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } req_t;

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      mem [DEPTH];

    req_t             req_in;
    req_t             req_c;
    logic             enter_ack_c;
    logic             oor_c;
    logic [AW-1:0]    widx_c;
    logic             unused_c;

    // Byte offset within the word has no meaning for a word RAM.
    assign unused_c = ^i_wb_adr[1:0];

    // Select the live bus fields in IDLE, the latched ones afterwards, and
    // flag the cycle whose closing edge enters ACK.
    always_comb begin
        req_in = '{word_adr: i_wb_adr[31:2], dat: i_wb_dat, sel: i_wb_sel, we: i_wb_we};
        req_c  = (state == S_IDLE) ? req_in : req_q;
        enter_ack_c = 1'b0;
        case (state)
            S_IDLE:  enter_ack_c = i_wb_cyc && (WAIT == 0);
            S_WAIT:  enter_ack_c = i_wb_cyc && (cnt == '0);
            default: enter_ack_c = 1'b0;
        endcase
        oor_c  = (req_c.word_adr >> AW) != 30'd0;
        widx_c = req_c.word_adr[AW-1:0];
    end

    // Control FSM with registered ack, read data, busy and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            req_q    <= '0;
            cnt      <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= 32'd0;
            o_err    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_wb_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_busy <= i_wb_cyc;
                    if (i_wb_cyc) begin
                        req_q <= req_in;
                        if (WAIT == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    o_busy <= i_wb_cyc;
                    if (!i_wb_cyc) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase

            if (enter_ack_c) begin
                o_wb_ack <= 1'b1;
                if (!req_c.we) begin
                    o_wb_rdt <= oor_c ? 32'd0 : mem[widx_c];
                end
                if (oor_c) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

    // Byte-lane write into the RAM at the edge entering ACK; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && enter_ack_c && req_c.we && !oor_c) begin
            for (int n = 0; n < 4; n++) begin
                if (req_c.sel[n]) begin
                    mem[widx_c][8*n +: 8] <= req_c.dat[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_serv_dbus_resp.sv
// Self-checking bench for serv_dbus_resp: one instance with WAIT=0 and one
// with WAIT=3, both AW=8, compared against a word-array memory model.
module tb_serv_dbus_resp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3, use3, cyc;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdt0, rdt3;
    logic        ack0, ack3, err0, err3, busy0, busy3;

    int errors = 0;
    int checks = 0;

    serv_dbus_resp #(.AW(8), .WAIT(0)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc & ~use3), .o_wb_rdt(rdt0), .o_wb_ack(ack0),
        .o_err(err0), .o_busy(busy0)
    );

    serv_dbus_resp #(.AW(8), .WAIT(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc & use3), .o_wb_rdt(rdt3), .o_wb_ack(ack3),
        .o_err(err3), .o_busy(busy3)
    );

    // Reference model: 256 words per instance, last read data, sticky error.
    logic [31:0] mdl [2][256];
    logic [31:0] mrdt [2];
    logic        merr [2];

    function automatic int wait_of(input bit d3);
        return d3 ? 3 : 0;
    endfunction

    function automatic logic [31:0] mread(input bit d3, input logic [31:0] a);
        if (a >= 32'd1024) return 32'd0;
        return mdl[d3][a / 4];
    endfunction

    // Apply one completed transaction to the model and return the expected rdt.
    function automatic logic [31:0] mapply(input bit d3, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] s,
                                           input bit w);
        logic [31:0] word;
        if (a >= 32'd1024) merr[d3] = 1'b1;
        if (w) begin
            if (a < 32'd1024) begin
                word = mdl[d3][a / 4];
                for (int b = 0; b < 4; b++)
                    if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                mdl[d3][a / 4] = word;
            end
        end else begin
            mrdt[d3] = mread(d3, a);
        end
        return mrdt[d3];
    endfunction

    // Drive one request and observe 16 cycles; no checking here.
    task automatic run_req(input bit d3, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit w, input int drop_at,
                           input int rst_at, input bit scramble,
                           output int n_ack, output int first_ack,
                           output logic [15:0] busy_m, output logic [31:0] rdt_ack);
        n_ack = 0; first_ack = -1; busy_m = '0; rdt_ack = '0;
        @(posedge clk); #1;
        use3 = d3; adr = a; dat = d; sel = s; we = w; cyc = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (d3 ? ack3 : ack0) begin
                n_ack++;
                if (first_ack < 0) first_ack = c;
                rdt_ack = d3 ? rdt3 : rdt0;
            end
            busy_m[c] = d3 ? busy3 : busy0;
            @(posedge clk); #1;
            rst0 = 1'b0; rst3 = 1'b0;
            if (first_ack >= 0 || c + 1 == drop_at) cyc = 1'b0;
            if (c + 1 == rst_at) begin
                cyc = 1'b0;
                if (d3) rst3 = 1'b1; else rst0 = 1'b1;
            end
            if (scramble && c == 0) begin
                adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack0, ack3, err0, err3, busy0, busy3} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000", {ack0, ack3, err0, err3, busy0, busy3});
        end
        checks++;
        if (rdt0 !== 32'd0 || rdt3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdt got=%h/%h want=0", rdt0, rdt3);
        end
        @(posedge clk); #1;
        rst0 = 1'b0; rst3 = 1'b0;
        mrdt[0] = 32'd0; mrdt[1] = 32'd0; merr[0] = 1'b0; merr[1] = 1'b0;
    endtask

    task automatic test_wait0;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        checks++;
        if (n !== 1 || f !== 1) begin
            errors++; $display("FAIL wait0_write_ack got n=%0d cyc=%0d want n=1 cyc=1", n, f);
        end
        checks++;
        if (bm !== 16'h0002) begin
            errors++; $display("FAIL wait0_busy got=%h want=0002", bm);
        end
        run_req(0, 32'h10, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h10, 32'h0, 4'h0, 0);
        checks++;
        if (n !== 1 || f !== 1 || r !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wait0_read got n=%0d cyc=%0d rdt=%h want 1/1/deadbeef", n, f, r);
        end
    endtask

    task automatic test_byte_lanes;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(0, 32'h20, 32'h11223344, 4'hF, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h20, 32'h11223344, 4'hF, 1);
        run_req(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        run_req(0, 32'h23, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h23, 32'h0, 4'h0, 0);
        checks++;
        if (r !== 32'h11BB33DD) begin
            errors++; $display("FAIL byte_lanes got=%h want=11bb33dd", r);
        end
        run_req(0, 32'h20, 32'h55667788, 4'h0, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h20, 32'h55667788, 4'h0, 1);
        run_req(0, 32'h20, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h20, 32'h0, 4'h0, 0);
        checks++;
        if (n !== 1 || r !== 32'h11BB33DD) begin
            errors++; $display("FAIL sel_none got n=%0d rdt=%h want 1/11bb33dd", n, r);
        end
    endtask

    task automatic test_wait3;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(1, 32'h40, 32'hCAFEF00D, 4'hF, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h40, 32'hCAFEF00D, 4'hF, 1);
        run_req(1, 32'h40, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h40, 32'h0, 4'h0, 0);
        checks++;
        if (n !== 1 || f !== 4) begin
            errors++; $display("FAIL wait3_ack got n=%0d cyc=%0d want n=1 cyc=4", n, f);
        end
        checks++;
        if (bm !== 16'h001E) begin
            errors++; $display("FAIL wait3_busy got=%h want=001e", bm);
        end
        checks++;
        if (r !== e) begin
            errors++; $display("FAIL wait3_rdt got=%h want=%h", r, e);
        end
    endtask

    task automatic test_abort;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(1, 32'h40, 32'h01234567, 4'hF, 1, 2, -1, 0, n, f, bm, r);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL abort_ack got n=%0d want 0", n);
        end
        checks++;
        if (bm !== 16'h0006) begin
            errors++; $display("FAIL abort_busy got=%h want=0006", bm);
        end
        run_req(1, 32'h40, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h40, 32'h0, 4'h0, 0);
        checks++;
        if (r !== 32'hCAFEF00D || r !== e) begin
            errors++; $display("FAIL abort_ram got=%h want=cafef00d", r);
        end
    endtask

    task automatic test_oor;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(0, 32'h0, 32'h12345678, 4'hF, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h0, 32'h12345678, 4'hF, 1);
        checks++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL oor_err_before got=%b want=0", err0);
        end
        run_req(0, 32'h400, 32'hFFFFFFFF, 4'hF, 1, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h400, 32'hFFFFFFFF, 4'hF, 1);
        checks++;
        if (n !== 1 || f !== 1 || err0 !== 1'b1) begin
            errors++; $display("FAIL oor_write got n=%0d cyc=%0d err=%b want 1/1/1", n, f, err0);
        end
        run_req(0, 32'h400, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h400, 32'h0, 4'h0, 0);
        checks++;
        if (r !== 32'd0) begin
            errors++; $display("FAIL oor_read got=%h want=0", r);
        end
        run_req(0, 32'h0, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(0, 32'h0, 32'h0, 4'h0, 0);
        checks++;
        if (r !== 32'h12345678 || err0 !== 1'b1) begin
            errors++; $display("FAIL oor_word0 got=%h err=%b want 12345678/1", r, err0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        int seen = 0;
        @(posedge clk); #1;
        use3 = 1'b0; adr = 32'h80; dat = 32'h5A5AA5A5; sel = 4'hF; we = 1'b1; cyc = 1'b1;
        e = mapply(0, 32'h80, 32'h5A5AA5A5, 4'hF, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ack got=%b want=1", ack0);
        end
        @(posedge clk); #1;
        we = 1'b0; dat = 32'h0;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got=%b want=0", ack0);
        end
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (ack0) seen = c + 1;
        end
        e = mapply(0, 32'h80, 32'h0, 4'h0, 0);
        checks++;
        if (seen !== 1 || rdt0 !== e) begin
            errors++; $display("FAIL b2b_read got cyc=%0d rdt=%h want cyc=1 rdt=%h", seen, rdt0, e);
        end
        @(posedge clk); #1;
        cyc = 1'b0;
    endtask

    task automatic test_random;
        int n, f; logic [15:0] bm; logic [31:0] r, e, a, d; logic [3:0] s; bit w;
        for (int di = 0; di < 2; di++) begin
            for (int k = 0; k < 8; k++) begin
                a = 32'(400 + 4 * k);
                d = $urandom;
                run_req(di[0], a, d, 4'hF, 1, -1, -1, 1, n, f, bm, r);
                e = mapply(di[0], a, d, 4'hF, 1);
            end
            for (int t = 0; t < 40; t++) begin
                if ($urandom_range(7) == 0) a = $urandom | 32'h400;
                else a = 32'(400 + 4 * $urandom_range(7) + $urandom_range(3));
                d = $urandom; s = 4'($urandom); w = 1'($urandom);
                run_req(di[0], a, d, s, w, -1, -1, 1, n, f, bm, r);
                e = mapply(di[0], a, d, s, w);
                checks++;
                if (n !== 1 || f !== 1 + wait_of(di[0])) begin
                    errors++;
                    $display("FAIL rand_ack dut=%0d t=%0d got n=%0d cyc=%0d want 1/%0d",
                             di, t, n, f, 1 + wait_of(di[0]));
                end
                checks++;
                if (r !== e) begin
                    errors++;
                    $display("FAIL rand_rdt dut=%0d t=%0d adr=%h we=%b got=%h want=%h", di, t, a, w, r, e);
                end
                checks++;
                if ((di == 1 ? err3 : err0) !== merr[di]) begin
                    errors++;
                    $display("FAIL rand_err dut=%0d t=%0d got=%b want=%b", di, t,
                             di == 1 ? err3 : err0, merr[di]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, f; logic [15:0] bm; logic [31:0] r, e;
        run_req(1, 32'h800, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h800, 32'h0, 4'h0, 0);
        run_req(1, 32'h40, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h40, 32'h0, 4'h0, 0);
        checks++;
        if (err3 !== 1'b1 || rdt3 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rstmid_pre got err=%b rdt=%h want 1/cafef00d", err3, rdt3);
        end
        run_req(1, 32'h40, 32'h87654321, 4'hF, 1, -1, 2, 0, n, f, bm, r);
        merr[1] = 1'b0; mrdt[1] = 32'd0;
        checks++;
        if (n !== 0 || bm !== 16'h0006) begin
            errors++; $display("FAIL rstmid_ack got n=%0d busy=%h want 0/0006", n, bm);
        end
        checks++;
        if (err3 !== 1'b0 || rdt3 !== 32'd0) begin
            errors++; $display("FAIL rstmid_clear got err=%b rdt=%h want 0/0", err3, rdt3);
        end
        run_req(1, 32'h40, 32'h0, 4'h0, 0, -1, -1, 0, n, f, bm, r);
        e = mapply(1, 32'h40, 32'h0, 4'h0, 0);
        checks++;
        if (n !== 1 || r !== 32'hCAFEF00D || r !== e) begin
            errors++; $display("FAIL rstmid_ram got n=%0d rdt=%h want 1/cafef00d", n, r);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst3 = 1'b1; use3 = 1'b0; cyc = 1'b0;
        adr = '0; dat = '0; sel = '0; we = 1'b0;
        test_reset();
        test_wait0();
        test_byte_lanes();
        test_wait3();
        test_abort();
        test_oor();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
